// File: rtl/cmos_pkg.sv
// Shared definitions for the CMOS capture front end: FSM states, default
// frame geometry and a counter-width helper.
package cmos_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    SKIP    = 2'd2,
    ACTIVE  = 2'd3
  } state_t;

  localparam int DEF_COL = 1280;
  localparam int DEF_ROW = 720;

  // Counter width for a 0..n-1 counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single slow-changing asynchronous level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      // NOTE: non-blocking so both flops sample the pre-edge values.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cmos_capture_gen.sv
// CMOS sensor capture: assembles bus beats into pixels, frames them with
// sop/eol/eop, decimates frames and flags short lines and truncated frames.
module cmos_capture_gen
  import cmos_pkg::*;
#(
  parameter int   DATA_W    = 8,
  parameter int   COL       = DEF_COL,
  parameter int   ROW       = DEF_ROW,
  parameter int   BPP       = 2,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic VS_POL    = 1'b1,
  parameter int   DECIM_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_capture,
  input  logic [DATA_W-1:0]       cmos_din,
  input  logic                    href,
  input  logic                    vsync,
  input  logic [DECIM_W-1:0]      decim,
  output logic [BPP*DATA_W-1:0]   dout,
  output logic                    dout_vld,
  output logic                    dout_sop,
  output logic                    dout_eol,
  output logic                    dout_eop,
  output logic [15:0]             frame_cnt,
  output logic                    err_line,
  output logic                    err_frame,
  output logic                    busy
);

  localparam int PIX_W  = BPP * DATA_W;
  localparam int BEAT_W = cnt_w(BPP);
  localparam int COL_W  = cnt_w(COL);
  localparam int ROW_W  = cnt_w(ROW);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BPP - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COL - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROW - 1);

  state_t              state, state_nxt, start_state;
  logic                en_sync;
  logic                vs_q;
  logic [DECIM_W-1:0]  skip;
  logic [BEAT_W-1:0]   beat;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic                line_done;
  logic [PIX_W-1:0]    shreg, pix_nxt, din_ext;

  logic frame_start, capture_beat, pix_done, line_end, frame_end;
  logic short_line, frame_over;

  sync_2ff #(.RST_VAL(1'b0)) u_en_sync (
    .clk (clk),
    .rst (rst),
    .d   (en_capture),
    .q   (en_sync)
  );

  assign frame_start  = (vsync == VS_POL) && (vs_q != VS_POL);
  // line_done blocks beats arriving after a full line until href drops.
  assign capture_beat = (state == ACTIVE) && href && !line_done;
  assign pix_done     = capture_beat && (beat == BEAT_LAST);
  assign line_end     = pix_done && (col == COL_LAST);
  assign frame_end    = line_end && (row == ROW_LAST);
  assign short_line   = (state == ACTIVE) && !href && !line_done &&
                        ((beat != '0) || (col != '0));
  assign frame_over   = frame_end || (short_line && (row == ROW_LAST));
  assign busy         = (state == ACTIVE);

  assign din_ext = PIX_W'(cmos_din);
  assign pix_nxt = MSB_FIRST ? ((shreg << DATA_W) | din_ext)
                             : ((shreg >> DATA_W) | (din_ext << (PIX_W - DATA_W)));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_nxt   = state;
    start_state = !en_sync ? IDLE : ((skip == '0) ? ACTIVE : SKIP);
    case (state)
      IDLE:          if (en_sync) state_nxt = WAIT_VS;
      WAIT_VS, SKIP: if (frame_start) state_nxt = start_state;
      ACTIVE: begin
        if (frame_start)     state_nxt = start_state;
        else if (frame_over) state_nxt = WAIT_VS;
      end
      default:       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q      <= ~VS_POL;
      skip      <= '0;
      beat      <= '0;
      col       <= '0;
      row       <= '0;
      line_done <= 1'b0;
      shreg     <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      dout_sop  <= 1'b0;
      dout_eol  <= 1'b0;
      dout_eop  <= 1'b0;
      frame_cnt <= '0;
      err_line  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      vs_q      <= vsync;
      dout_vld  <= 1'b0;
      dout_sop  <= 1'b0;
      dout_eol  <= 1'b0;
      dout_eop  <= 1'b0;
      err_line  <= 1'b0;
      err_frame <= 1'b0;

      if (frame_start) skip <= (skip == decim) ? '0 : skip + 1'b1;

      if (capture_beat) begin
        shreg <= pix_nxt;
        beat  <= pix_done ? '0 : beat + 1'b1;
        if (pix_done) begin
          dout     <= pix_nxt;
          dout_vld <= 1'b1;
          dout_sop <= (col == '0) && (row == '0);
          if (line_end) begin
            dout_eol  <= 1'b1;
            col       <= '0;
            row       <= row + 1'b1;
            line_done <= 1'b1;
            if (frame_end) begin
              dout_eop  <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
      end

      if (!href) line_done <= 1'b0;

      // Short line: drop partial beats and move on to the next row without eol.
      if (short_line) begin
        err_line <= 1'b1;
        beat     <= '0;
        col      <= '0;
        row      <= row + 1'b1;
      end

      if (frame_start && (state == ACTIVE) && !frame_over) err_frame <= 1'b1;

      // Position counters restart at every frame start and whenever not capturing.
      if (frame_start || (state_nxt != ACTIVE)) begin
        beat      <= '0;
        col       <= '0;
        row       <= '0;
        line_done <= 1'b0;
      end
    end
  end

endmodule
